// File: rtl/movement_pkg.sv
// Shared definitions for the sprite movement controller and its datapath:
// control codes, screen and sprite geometry, state type and key bundle.
package movement_pkg;

  // Control codes seen by the datapath. The controller's state register
  // carries these values directly, so control needs no output decode.
  localparam logic [3:0] CTRL_HOLD    = 4'b0000;
  localparam logic [3:0] CTRL_CLEAR   = 4'b0001;
  localparam logic [3:0] CTRL_RIGHT   = 4'b0010;
  localparam logic [3:0] CTRL_LEFT    = 4'b0011;
  localparam logic [3:0] CTRL_PREHOLD = 4'b0100;
  localparam logic [3:0] CTRL_DRAW    = 4'b0101;
  localparam logic [3:0] CTRL_DOWN    = 4'b0110;
  localparam logic [3:0] CTRL_UP      = 4'b0111;

  // Screen and sprite geometry in pixels.
  localparam int SCREEN_W    = 160;
  localparam int SCREEN_H    = 120;
  localparam int SPRITE_SIZE = 4;

  // Largest top-left coordinate that keeps the whole sprite on screen.
  localparam int X_LIMIT = SCREEN_W - SPRITE_SIZE;
  localparam int Y_LIMIT = SCREEN_H - SPRITE_SIZE;

  typedef enum logic [3:0] {
    S_HOLD    = CTRL_HOLD,
    S_CLEAR   = CTRL_CLEAR,
    S_RIGHT   = CTRL_RIGHT,
    S_LEFT    = CTRL_LEFT,
    S_PREHOLD = CTRL_PREHOLD,
    S_DRAW    = CTRL_DRAW,
    S_DOWN    = CTRL_DOWN,
    S_UP      = CTRL_UP
  } move_state_e;

  // Bit order matches the {left, right, up, down} packing used at the top.
  typedef struct packed {
    logic left;
    logic right;
    logic up;
    logic down;
  } keys_t;

  // Net move along one axis from an opposing key pair. S_DRAW stands for
  // "no move on this axis": pressing both or neither cancels out.
  function automatic move_state_e axis_move(input logic neg_key,
                                            input logic pos_key,
                                            input move_state_e neg_state,
                                            input move_state_e pos_state);
    move_state_e result;
    result = S_DRAW;
    if (neg_key && !pos_key) begin
      result = neg_state;
    end else if (pos_key && !neg_key) begin
      result = pos_state;
    end
    return result;
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser bringing the four raw direction buttons into the
// clk domain. Adds two cycles of latency; both stages clear on reset.
module key_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] keys_i,
  output logic [3:0] keys_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  for (genvar gi = 0; gi < 4; gi++) begin : g_sync
    // Per-key two-stage resampling; only sync_q is used downstream.
    always_ff @(posedge clk) begin
      if (reset) begin
        meta_q[gi] <= 1'b0;
        sync_q[gi] <= 1'b0;
      end else begin
        meta_q[gi] <= keys_i[gi];
        sync_q[gi] <= meta_q[gi];
      end
    end
  end

  assign keys_o = sync_q;

endmodule

// File: rtl/movement_control_fsm.sv
// Sprite movement controller. Once per frame tick, while a direction key is
// held, it runs clear -> move -> redraw against the datapath, issuing the
// control code and maintaining the sprite's top-left position.
// Build option DIAG_MOVE_EN: when defined, a horizontal and a vertical move
// may both happen in one frame; otherwise at most one move per frame, with
// horizontal taking priority.
module movement_control_fsm
  import movement_pkg::*;
#(
  parameter int TICK_DIV = 833333,
  parameter int X_INIT   = 50,
  parameter int Y_INIT   = 50,
  parameter int X_MAX    = X_LIMIT,
  parameter int Y_MAX    = Y_LIMIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       done,
  output logic [3:0] control,
  output logic [7:0] x_pos,
  output logic [6:0] y_pos,
  output logic       busy
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [7:0] X_INIT_C = X_INIT[7:0];
  localparam logic [6:0] Y_INIT_C = Y_INIT[6:0];
  localparam logic [7:0] X_MAX_C  = X_MAX[7:0];
  localparam logic [6:0] Y_MAX_C  = Y_MAX[6:0];

  // ---------------------------------------------------------------------
  // Key synchronisation
  // ---------------------------------------------------------------------
  logic [3:0] keys_raw;
  logic [3:0] keys_sync;
  keys_t      keys_now;

  assign keys_raw = {key_left, key_right, key_up, key_down};
  assign keys_now = keys_t'(keys_sync);

  key_sync u_key_sync (
    .clk    (clk),
    .reset  (reset),
    .keys_i (keys_raw),
    .keys_o (keys_sync)
  );

  // ---------------------------------------------------------------------
  // Frame tick
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tick_wrap;
  logic             tick_pend_q;
  logic             tick_pend_d;
  logic             tick_consume;

  move_state_e state_q;

  assign tick_wrap    = (cnt_q == CNT_LAST);
  assign cnt_d        = tick_wrap ? '0 : cnt_q + CNT_W'(1);
  // A wrap on the consuming cycle wins, so a fresh tick is never lost; a
  // wrap while already pending simply leaves the flag set.
  assign tick_consume = (state_q == S_HOLD) && tick_pend_q;
  assign tick_pend_d  = tick_wrap | (tick_pend_q & ~tick_consume);

  // Free-running frame divider plus the single-entry pending-tick flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      tick_pend_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      tick_pend_q <= tick_pend_d;
    end
  end

  // ---------------------------------------------------------------------
  // Move planning from the synchronised keys
  // ---------------------------------------------------------------------
  move_state_e h_sel;
  move_state_e v_sel;
  move_state_e first_sel;
  move_state_e follow_sel;
  logic        any_key;

  assign any_key = |keys_sync;

  // Choose the first move state and the one that follows it; S_DRAW means
  // "nothing more to move".
  always_comb begin
    h_sel     = axis_move(keys_now.left, keys_now.right, S_LEFT, S_RIGHT);
    v_sel     = axis_move(keys_now.up, keys_now.down, S_UP, S_DOWN);
    first_sel = (h_sel != S_DRAW) ? h_sel : v_sel;
`ifdef DIAG_MOVE_EN
    follow_sel = (h_sel != S_DRAW) ? v_sel : S_DRAW;
`else
    follow_sel = S_DRAW;
`endif
  end

  // ---------------------------------------------------------------------
  // Saturating position update for the current move state
  // ---------------------------------------------------------------------
  logic [7:0] x_q;
  logic [7:0] x_d;
  logic [6:0] y_q;
  logic [6:0] y_d;

  // Next position; a move at the screen edge leaves the coordinate alone.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    case (state_q)
      S_LEFT:  if (x_q != 8'd0)    x_d = x_q - 8'd1;
      S_RIGHT: if (x_q < X_MAX_C)  x_d = x_q + 8'd1;
      S_UP:    if (y_q != 7'd0)    y_d = y_q - 7'd1;
      S_DOWN:  if (y_q < Y_MAX_C)  y_d = y_q + 7'd1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  // The move to run after the current one. Captured alongside the key
  // sample on the CLEAR exit, so later key changes cannot alter the frame.
  move_state_e follow_q;

  // Frame sequencer: paint, idle for a tick, clear, move, repaint.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_DRAW;
      follow_q <= S_DRAW;
      x_q      <= X_INIT_C;
      y_q      <= Y_INIT_C;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      case (state_q)
        S_DRAW: begin
          if (done) state_q <= S_PREHOLD;
        end
        S_PREHOLD: begin
          // One idle cycle lets the datapath drop its done pulse.
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          if (tick_pend_q && any_key) state_q <= S_CLEAR;
        end
        S_CLEAR: begin
          if (done) begin
            state_q  <= first_sel;
            follow_q <= follow_sel;
          end
        end
        S_LEFT, S_RIGHT: begin
          state_q  <= follow_q;
          follow_q <= S_DRAW;
        end
        S_UP, S_DOWN: begin
          state_q  <= S_DRAW;
          follow_q <= S_DRAW;
        end
        default: begin
          state_q  <= S_DRAW;
          follow_q <= S_DRAW;
        end
      endcase
    end
  end

  assign control = state_q;
  assign x_pos   = x_q;
  assign y_pos   = y_q;
  assign busy    = (state_q != S_HOLD);

endmodule
